// File: rtl/core_pkg.sv
// core_pkg: shared address map, address type and next-PC select encoding for the pipelined MIPS core
package core_pkg;
  localparam int WIDTH = 32;
  localparam logic [WIDTH-1:0] RESET_VEC = 32'h0000_3000;
  localparam logic [WIDTH-1:0] EXC_VEC   = 32'h0000_4180;
  localparam logic [WIDTH-1:0] IMEM_BASE = 32'h0000_3000;
  localparam logic [WIDTH-1:0] IMEM_SIZE = 32'h0000_3000;
  typedef logic [WIDTH-1:0] addr_t;
  typedef enum logic [2:0] {SEL_EXC, SEL_ERET, SEL_BR, SEL_PEND, SEL_HOLD, SEL_SEQ} npc_sel_e;
endpackage

// File: rtl/pc_range_chk.sv
// pc_range_chk: combinational alignment/window check; addr in, exc=1 when misaligned or outside [IMEM_BASE, IMEM_BASE+IMEM_SIZE)
module pc_range_chk #(
  parameter int WIDTH = core_pkg::WIDTH,
  parameter logic [WIDTH-1:0] IMEM_BASE = core_pkg::IMEM_BASE,
  parameter logic [WIDTH-1:0] IMEM_SIZE = core_pkg::IMEM_SIZE,
  parameter int ALIGN_BITS = 2
) (
  input  logic [WIDTH-1:0] addr,
  output logic             exc
);
  // Upper bound in WIDTH+1 bits so a window ending at 2^WIDTH stays representable
  logic [WIDTH:0] limit;
  assign limit = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};
  assign exc = (addr[ALIGN_BITS-1:0] != '0) || (addr < IMEM_BASE) || ({1'b0, addr} >= limit);
endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch PC with sequential step, branch/exception/ERET redirects and stall-deferred branches;
// ports: clk, reset, stall_i, br_valid_i/br_target_i, exc_valid_i, eret_valid_i/epc_i -> pc_o, pc_seq_o, fetch_exc_o, pend_valid_o
module pc_unit #(
  parameter int WIDTH = core_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RESET_VEC = core_pkg::RESET_VEC,
  parameter logic [WIDTH-1:0] EXC_VEC = core_pkg::EXC_VEC,
  parameter logic [WIDTH-1:0] IMEM_BASE = core_pkg::IMEM_BASE,
  parameter logic [WIDTH-1:0] IMEM_SIZE = core_pkg::IMEM_SIZE,
  parameter int STEP = 4,
  parameter int ALIGN_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             br_valid_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             exc_valid_i,
  input  logic             eret_valid_i,
  input  logic [WIDTH-1:0] epc_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_seq_o,
  output logic             fetch_exc_o,
  output logic             pend_valid_o
);
  import core_pkg::*;
  npc_sel_e sel;
  logic [WIDTH-1:0] pc_nxt, pend_tgt;
  logic pend_v, redirect;
  assign redirect = exc_valid_i || eret_valid_i;
  assign pc_seq_o = pc_o + WIDTH'(STEP);
  assign pend_valid_o = pend_v;
  always_comb begin
    sel = exc_valid_i ? SEL_EXC :
          eret_valid_i ? SEL_ERET :
          (br_valid_i && !stall_i) ? SEL_BR :
          stall_i ? SEL_HOLD :
          pend_v ? SEL_PEND : SEL_SEQ;
    pc_nxt = sel == SEL_EXC  ? EXC_VEC :
             sel == SEL_ERET ? epc_i :
             sel == SEL_BR   ? br_target_i :
             sel == SEL_PEND ? pend_tgt :
             sel == SEL_HOLD ? pc_o : pc_seq_o;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_o <= RESET_VEC;
      pend_v <= 1'b0;
      pend_tgt <= '0;
    end else begin
      pc_o <= pc_nxt;
      // Pending survives only while stalled and not flushed; a stalled branch (re)loads it
      pend_v <= !redirect && stall_i && (br_valid_i || pend_v);
      if (!redirect && stall_i && br_valid_i) pend_tgt <= br_target_i;
    end
  end
  pc_range_chk #(
    .WIDTH(WIDTH), .IMEM_BASE(IMEM_BASE), .IMEM_SIZE(IMEM_SIZE), .ALIGN_BITS(ALIGN_BITS)
  ) u_chk (
    .addr(pc_o),
    .exc(fetch_exc_o)
  );
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the pipelined MIPS core. It replaces the single-cycle PC register. It holds the fetch address, advances it sequentially, and accepts branch/jump redirects, exception entry and ERET return. It supports fetch stalls, and a branch redirect that arrives during a stall is held in a pending register until the stall releases. It also flags illegal fetch addresses (misaligned or outside instruction memory) to the exception logic.

Parameters:
WIDTH, 32, address width in bits
RESET_VEC, 32'h0000_3000, PC value loaded on reset
EXC_VEC, 32'h0000_4180, exception handler entry address
IMEM_BASE, 32'h0000_3000, lowest legal fetch address (inclusive)
IMEM_SIZE, 32'h0000_3000, legal fetch window size in bytes; legal window is [IMEM_BASE, IMEM_BASE+IMEM_SIZE)
STEP, 4, sequential increment in bytes
ALIGN_BITS, 2, number of low address bits that must be zero

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
stall_i  input  1  freeze PC (IF/ID hazard stall)
br_valid_i  input  1  branch/jump redirect request from ID
br_target_i  input  WIDTH  redirect target
exc_valid_i  input  1  exception taken; jump to EXC_VEC
eret_valid_i  input  1  ERET executed; jump to epc_i
epc_i  input  WIDTH  return address from CP0
pc_o  output  WIDTH  current fetch address (registered)
pc_seq_o  output  WIDTH  pc_o+STEP, wraps modulo 2^WIDTH (combinational)
fetch_exc_o  output  1  AdEL on fetch: pc_o misaligned or outside window (combinational)
pend_valid_o  output  1  a deferred branch redirect is held

Behaviour:
- Reset (synchronous, active-high; clock clk): pc_o<=RESET_VEC, pending valid<=0, pending target<=0. Reset overrides every other input. fetch_exc_o then follows from RESET_VEC.
- Next-PC priority at each posedge, highest first:
  1. exc_valid_i: pc<=EXC_VEC; pending cleared. Ignores stall.
  2. eret_valid_i: pc<=epc_i; pending cleared. Ignores stall.
  3. br_valid_i with stall_i=0: pc<=br_target_i; pending cleared.
  4. br_valid_i with stall_i=1: pc held; pending target<=br_target_i; pending valid<=1. A newer request overwrites an older pending one.
  5. pending valid with stall_i=0 and no new request: pc<=pending target; pending cleared.
  6. stall_i=1: pc held.
  7. Otherwise: pc<=pc_o+STEP.
- exc and eret asserted together: exc wins.
- Latency: one cycle. A redirect sampled at edge N is visible on pc_o after edge N. A pending redirect is applied at the first non-stalled edge.
- pc_seq_o wraps: for WIDTH=32, 32'hFFFF_FFFC gives 0.
- fetch_exc_o=1 if pc_o[ALIGN_BITS-1:0]!=0, pc_o<IMEM_BASE, or pc_o>=IMEM_BASE+IMEM_SIZE.
  - Compute the window bound in WIDTH+1 bits so a window ending at 2^WIDTH does not overflow.
  - The PC keeps advancing; the core is expected to raise exc_valid_i.
- Misaligned targets are accepted as-is, so the fault surfaces through fetch_exc_o.
- pend_valid_o is the registered pending-valid bit.

Decomposition:
- Shared package core_pkg:
  - constants RESET_VEC, EXC_VEC, IMEM_BASE, IMEM_SIZE
  - typedef addr_t (logic [WIDTH-1:0])
  - enum npc_sel_e {SEL_EXC, SEL_ERET, SEL_BR, SEL_PEND, SEL_HOLD, SEL_SEQ}
- One natural sub-module, pc_range_chk: purely combinational alignment and window check producing fetch_exc_o. It is reusable later for data-address AdEL/AdES.

Test Plan:
- Reset, then 3 free cycles -> pc_o = 3000, 3004, 3008, 300C; fetch_exc_o=0; pend_valid_o=0.
- At pc 3008: br_valid_i=1, target 3100, stall_i=0 -> next pc_o=3100, then 3104.
- At pc 3008, stall_i=1 for 2 cycles:
  - br 3200 in cycle 1, br 3300 in cycle 2 -> pc_o holds 3008 and pend_valid_o=1.
  - Release stall -> pc_o=3300; pend_valid_o=0.
- stall_i=1 with exc_valid_i=1, eret_valid_i=1, pending 3200 held -> pc_o=4180, pend_valid_o=0. Next cycle eret_valid_i=1, epc_i=3010 -> pc_o=3010.
- br target 3002 -> fetch_exc_o=1 at pc_o=3002. br target 2FFC -> fetch_exc_o=1. br target 5FFC -> fetch_exc_o=0. Sequential step to 6000 -> fetch_exc_o=1.
- Reset asserted while pending valid and stall_i=1 -> pc_o=3000, pend_valid_o=0 after the edge. WIDTH=32 with forced branch to FFFFFFFC -> pc_seq_o=0 and the next sequential pc_o=0.
